// File: rtl/bcd_timekeeper.sv
// BCD hh:mm:ss timekeeper with debounced mode/inc keys and a RUN/SET_H/SET_M/SET_S state machine.
// Optional field blinking while setting is enabled by defining SET_BLINK_EN.
module bcd_timekeeper #(
    parameter int TICK_DIV = 1000,
    parameter int DEB_CYC  = 20
) (
    input  logic        clk1khz,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] dispnum,
    output logic [1:0]  mode,
    output logic        sec_tick,
    output logic        hour_chime
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC - 1);

    state_t state, state_nxt;

    logic [1:0]    key_raw, sync_a, sync_b, key_lvl, key_lvl_q, key_press;
    logic [DW-1:0] deb_cnt [2];
    logic          mode_press, inc_press;

    logic [PW-1:0] presc;
    logic          tick, tick_q, chime_q, chime_nxt;
    logic [7:0]    hr, mn, sc, hr_nxt, mn_nxt, sc_nxt;
    logic [23:0]   disp_nxt;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)          r = 8'h00;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Bit 0 is the mode key, bit 1 the inc key; a level flips only after DEB_CYC equal samples.
    assign key_raw = {key_inc, key_mode};

    always_ff @(posedge clk1khz or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= '0;
            sync_b    <= '0;
            key_lvl   <= '0;
            key_lvl_q <= '0;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            sync_a    <= key_raw;
            sync_b    <= sync_a;
            key_lvl_q <= key_lvl;
            for (int k = 0; k < 2; k++) begin
                if (sync_b[k] == key_lvl[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_MAX) begin
                    key_lvl[k] <= sync_b[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    assign key_press  = key_lvl & ~key_lvl_q;
    assign mode_press = key_press[0];
    assign inc_press  = key_press[1];

    assign tick = (state == RUN) && (presc == PRESC_MAX);
    assign mode = state;

    always_comb begin
        state_nxt = state;
        hr_nxt    = hr;
        mn_nxt    = mn;
        sc_nxt    = sc;
        chime_nxt = 1'b0;
        if (tick) begin
            sc_nxt = inc60(sc);
            if (sc == 8'h59) begin
                mn_nxt = inc60(mn);
                if (mn == 8'h59) begin
                    hr_nxt    = inc24(hr);
                    chime_nxt = 1'b1;
                end
            end
        end
        // A mode press wins over a simultaneous inc press.
        if (mode_press) begin
            unique case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                SET_S:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end else if (inc_press) begin
            unique case (state)
                SET_H:   hr_nxt = inc24(hr);
                SET_M:   mn_nxt = inc60(mn);
                SET_S:   sc_nxt = inc60(sc);
                default: ;
            endcase
        end
    end

`ifdef SET_BLINK_EN
    localparam logic [PW-1:0] BLINK_AT = PW'(TICK_DIV / 2);

    always_comb begin
        disp_nxt = {hr, mn, sc};
        if (presc >= BLINK_AT) begin
            unique case (state)
                SET_H:   disp_nxt[23:16] = 8'hFF;
                SET_M:   disp_nxt[15:8]  = 8'hFF;
                SET_S:   disp_nxt[7:0]   = 8'hFF;
                default: ;
            endcase
        end
    end
`else
    assign disp_nxt = {hr, mn, sc};
`endif

    always_ff @(posedge clk1khz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            presc      <= '0;
            hr         <= 8'h00;
            mn         <= 8'h00;
            sc         <= 8'h00;
            tick_q     <= 1'b0;
            chime_q    <= 1'b0;
            sec_tick   <= 1'b0;
            hour_chime <= 1'b0;
            dispnum    <= 24'h000000;
        end else begin
            state <= state_nxt;
            // Leaving SET_S restarts the second so the first tick is a full period away.
            if ((state == SET_S) && mode_press) presc <= '0;
            else if (presc == PRESC_MAX)        presc <= '0;
            else                                presc <= presc + PW'(1);
            hr         <= hr_nxt;
            mn         <= mn_nxt;
            sc         <= sc_nxt;
            tick_q     <= tick;
            chime_q    <= chime_nxt;
            sec_tick   <= tick_q;
            hour_chime <= chime_q;
            dispnum    <= disp_nxt;
        end
    end

endmodule
